qos_arbiter: RTL and testbench

QOS_ARBITER -- requirements
Module: qos_arbiter

---
 rtl/qos_arbiter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_qos_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/qos_arbiter.sv
// QoS arbiter: round-robin / weighted round-robin grant FSM with per-channel completion counters.
// Optional starvation promotion is compiled in with the macro QOS_STARVE_EN.
module qos_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int WEIGHT_W     = 4,
    parameter int STARVE_LIMIT = 64,
    localparam int IDX_W       = $clog2(NUM_CH)
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [NUM_CH-1:0]            req,
    input  logic                         done,
    input  logic                         mode,
    input  logic [NUM_CH*WEIGHT_W-1:0]   weight,
    input  logic                         clr_stats,
    output logic [NUM_CH-1:0]            grant,
    output logic                         grant_valid,
    output logic [IDX_W-1:0]             grant_idx,
    output logic [NUM_CH*CNT_W-1:0]      count,
    output logic [NUM_CH-1:0]            starve
);

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("qos_arbiter: NUM_CH must be 2..16");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 65535) begin : g_bad_starve_limit
        $error("qos_arbiter: STARVE_LIMIT must be 1..65535");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WEIGHT_W-1:0] CREDIT_ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_CH-1:0]   GRANT_ONE  = {{(NUM_CH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]    PTR_RST    = IDX_W'(NUM_CH - 1);

    // First requester strictly after p in circular order; iterating downward lets the nearest one win.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CH-1:0] r, input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] pick;
        pick = {IDX_W{1'b0}};
        for (int k = NUM_CH; k >= 1; k--) begin
            if (r[(int'(p) + k) % NUM_CH]) begin
                pick = IDX_W'((int'(p) + k) % NUM_CH);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_pick(input logic [NUM_CH-1:0] r);
        logic [IDX_W-1:0] pick;
        pick = {IDX_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r[i]) begin
                pick = IDX_W'(i);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    state_e                     state_r, state_nxt_s;
    logic [NUM_CH-1:0]          grant_r, grant_nxt_s;
    logic                       grant_valid_r, grant_valid_nxt_s;
    logic [IDX_W-1:0]           grant_idx_r, grant_idx_nxt_s;
    logic [NUM_CH*CNT_W-1:0]    count_r, count_nxt_s;
    logic [WEIGHT_W-1:0]        credit_r, credit_nxt_s;
    logic [IDX_W-1:0]           ptr_r, ptr_nxt_s;
    logic                       mode_r, mode_nxt_s;
    logic [IDX_W-1:0]           winner_s;
    logic [WEIGHT_W-1:0]        weight_win_s;
    logic                       preempt_s;
    logic                       stay_s;
    logic                       busy_done_s;

`ifdef QOS_STARVE_EN
    localparam logic [15:0] LIMIT16 = 16'(STARVE_LIMIT);

    logic [NUM_CH-1:0][15:0]    wait_r, wait_nxt_s;
    logic [NUM_CH-1:0]          starve_r, starve_nxt_s;
    logic [NUM_CH-1:0]          starve_req_s;

    assign starve_req_s = starve_r & req;
    // A starving channel other than the current owner cuts a weighted burst short.
    assign preempt_s    = |(starve_r & req & ~grant_r);
    assign starve       = starve_r;
`else
    assign preempt_s    = 1'b0;
    assign starve       = {NUM_CH{1'b0}};
`endif

    assign busy_done_s = (state_r == ST_BUSY) && done;
    assign stay_s      = mode_r && (credit_r > CREDIT_ONE) && req[grant_idx_r] && !preempt_s;

    // Arbitration winner and its credit load value (zero weight behaves as one).
    always_comb begin
        winner_s     = rr_pick(req, ptr_r);
`ifdef QOS_STARVE_EN
        if (|starve_req_s) begin
            winner_s = lowest_pick(starve_req_s);
        end else begin
            winner_s = rr_pick(req, ptr_r);
        end
`endif
        weight_win_s = weight[winner_s*WEIGHT_W +: WEIGHT_W];
        if (weight_win_s == {WEIGHT_W{1'b0}}) begin
            weight_win_s = CREDIT_ONE;
        end else begin
            weight_win_s = weight_win_s;
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done && !stay_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of grant, pointer, credit and sampled mode.
    always_comb begin
        grant_nxt_s       = grant_r;
        grant_valid_nxt_s = grant_valid_r;
        grant_idx_nxt_s   = grant_idx_r;
        ptr_nxt_s         = ptr_r;
        credit_nxt_s      = credit_r;
        mode_nxt_s        = mode_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    grant_nxt_s       = GRANT_ONE << winner_s;
                    grant_valid_nxt_s = 1'b1;
                    grant_idx_nxt_s   = winner_s;
                    ptr_nxt_s         = winner_s;
                    credit_nxt_s      = weight_win_s;
                    mode_nxt_s        = mode;
                end else begin
                    grant_nxt_s       = {NUM_CH{1'b0}};
                    grant_valid_nxt_s = 1'b0;
                    grant_idx_nxt_s   = {IDX_W{1'b0}};
                end
            end
            ST_BUSY: begin
                if (done && stay_s) begin
                    credit_nxt_s      = credit_r - CREDIT_ONE;
                end else if (done) begin
                    grant_nxt_s       = {NUM_CH{1'b0}};
                    grant_valid_nxt_s = 1'b0;
                    grant_idx_nxt_s   = {IDX_W{1'b0}};
                    credit_nxt_s      = {WEIGHT_W{1'b0}};
                end else begin
                    credit_nxt_s      = credit_r;
                end
            end
            default: begin
                grant_nxt_s       = {NUM_CH{1'b0}};
                grant_valid_nxt_s = 1'b0;
                grant_idx_nxt_s   = {IDX_W{1'b0}};
                credit_nxt_s      = {WEIGHT_W{1'b0}};
            end
        endcase
    end

    // Completion counters: clear beats increment, increment saturates.
    always_comb begin
        count_nxt_s = count_r;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr_stats) begin
                count_nxt_s[i*CNT_W +: CNT_W] = {CNT_W{1'b0}};
            end else if (busy_done_s && (grant_idx_r == IDX_W'(i)) &&
                         (count_r[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                count_nxt_s[i*CNT_W +: CNT_W] = count_r[i*CNT_W +: CNT_W] + CNT_ONE;
            end else begin
                count_nxt_s[i*CNT_W +: CNT_W] = count_r[i*CNT_W +: CNT_W];
            end
        end
    end

    // Output and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant_r       <= {NUM_CH{1'b0}};
            grant_valid_r <= 1'b0;
            grant_idx_r   <= {IDX_W{1'b0}};
            count_r       <= {(NUM_CH*CNT_W){1'b0}};
            credit_r      <= {WEIGHT_W{1'b0}};
            ptr_r         <= PTR_RST;
            mode_r        <= 1'b0;
        end else begin
            grant_r       <= grant_nxt_s;
            grant_valid_r <= grant_valid_nxt_s;
            grant_idx_r   <= grant_idx_nxt_s;
            count_r       <= count_nxt_s;
            credit_r      <= credit_nxt_s;
            ptr_r         <= ptr_nxt_s;
            mode_r        <= mode_nxt_s;
        end
    end

`ifdef QOS_STARVE_EN
    // Wait counters clear on the edge that grants the channel, so the flag drops with grant rising.
    always_comb begin
        wait_nxt_s   = wait_r;
        starve_nxt_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (!req[i] || grant_nxt_s[i]) begin
                wait_nxt_s[i] = 16'h0000;
            end else if (wait_r[i] != 16'hFFFF) begin
                wait_nxt_s[i] = wait_r[i] + 16'h0001;
            end else begin
                wait_nxt_s[i] = wait_r[i];
            end
            starve_nxt_s[i] = (wait_nxt_s[i] >= LIMIT16);
        end
    end

    // Wait counter and starvation flag registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_r   <= {(NUM_CH*16){1'b0}};
            starve_r <= {NUM_CH{1'b0}};
        end else begin
            wait_r   <= wait_nxt_s;
            starve_r <= starve_nxt_s;
        end
    end
`endif

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_idx   = grant_idx_r;
    assign count       = count_r;

endmodule

// File: tb/tb_qos_arbiter.sv
// Directed bench for qos_arbiter: stimulus queues expected grant order, a monitor checks each new grant.
module tb_qos_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  req;
    logic        done;
    logic        mode;
    logic [15:0] weight;
    logic        clr_stats;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [15:0] count;
    logic [3:0]  starve;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic prev_valid = 1'b0;

    qos_arbiter #(
        .NUM_CH(4), .CNT_W(4), .WEIGHT_W(4), .STARVE_LIMIT(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req), .done(done),
        .mode(mode), .weight(weight), .clr_stats(clr_stats),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .count(count), .starve(starve)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising grant_valid consumes one expected channel.
    always @(negedge sys_clk) begin
        if (grant_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected actual=%0d required=none", grant_idx);
            end else begin
                chk("grant_idx", 32'(grant_idx), 32'(exp_q[0]));
                chk("grant_onehot", 32'(grant), 32'(1) << exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        prev_valid <= grant_valid;
    end

    task automatic wait_grant();
        int n = 0;
        while (!grant_valid && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        if (!grant_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_grant timeout actual=0 required=1");
        end
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge sys_clk);
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0; req = 4'b0000; done = 1'b0; mode = 1'b0;
        weight = 16'h0000; clr_stats = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_starve", 32'(starve), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Round-robin over all four channels, starting at channel 0.
        req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        @(negedge sys_clk);
        chk("grant_latency", 32'(grant_valid), 32'd1);
        for (int g = 0; g < 4; g++) begin
            wait_grant();
            pulse_done();
            chk("rr_idle_after_done", 32'(grant_valid), 32'd0);
        end
        for (int i = 0; i < 4; i++) chk("rr_count_one", 32'(count[i*4 +: 4]), 32'd1);
        wait_grant();
        req = 4'b0000;
        pulse_done();
        chk("rr_count0_two", 32'(count[3:0]), 32'd2);
        pulse_done();
        chk("idle_done_ignored", 32'(count), 32'h1112);

        // clr_stats coinciding with done on channel 1.
        req = 4'b0010;
        exp_q.push_back(1);
        wait_grant();
        done = 1'b1; clr_stats = 1'b1;
        @(negedge sys_clk);
        done = 1'b0; clr_stats = 1'b0; req = 4'b0000;
        chk("clr_wins", 32'(count), 32'd0);

        // Weighted: ch0 weight 3 holds for three dones, then one idle cycle, then ch1.
        mode = 1'b1; weight = 16'h0013; req = 4'b0011;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        wait_grant();
        for (int k = 0; k < 2; k++) begin
            pulse_done();
            chk("wrr_hold_valid", 32'(grant_valid), 32'd1);
            chk("wrr_hold_idx", 32'(grant_idx), 32'd0);
        end
        pulse_done();
        chk("wrr_idle_gap", 32'(grant_valid), 32'd0);
        chk("wrr_count0", 32'(count[3:0]), 32'd3);
        @(negedge sys_clk);
        chk("wrr_gap_one_cycle", 32'(grant_valid), 32'd1);
        chk("wrr_then_ch1", 32'(grant_idx), 32'd1);
        pulse_done();
        wait_grant();
        req = 4'b0000;
        pulse_done();
        chk("wrr_count1", 32'(count[7:4]), 32'd1);
        chk("wrr_count0_final", 32'(count[3:0]), 32'd4);

        // Zero weight behaves as one: a single done releases the channel.
        weight = 16'h0000; req = 4'b0001;
        exp_q.push_back(0);
        wait_grant();
        pulse_done();
        chk("w0_as_one", 32'(grant_valid), 32'd0);
        req = 4'b0000;

        // Counter saturation on channel 2.
        mode = 1'b0;
        clr_stats = 1'b1;
        @(negedge sys_clk);
        clr_stats = 1'b0;
        chk("clr_pulse", 32'(count), 32'd0);
        req = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(2);
            wait_grant();
            if (i == 15) req = 4'b0000;
            pulse_done();
            if (i == 14) chk("cnt_reach_max", 32'(count[11:8]), 32'd15);
        end
        chk("cnt_sat_hold", 32'(count[11:8]), 32'd15);

        // Asynchronous reset in the middle of a grant.
        req = 4'b1000;
        exp_q.push_back(3);
        wait_grant();
        #2 sys_rst_n = 1'b0;
        #1 chk("rst_async_grant", 32'(grant), 32'd0);
        chk("rst_async_valid", 32'(grant_valid), 32'd0);
        @(negedge sys_clk);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_idx", 32'(grant_idx), 32'd0);
        sys_rst_n = 1'b1; req = 4'b1111;
        exp_q.push_back(0);
        wait_grant();
        req = 4'b0000;
        pulse_done();

`ifdef QOS_STARVE_EN
        // Starvation: ch1 flags after 8 wait cycles and pre-empts ch0's remaining credit.
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mode = 1'b1; weight = 16'h000F; req = 4'b0011;
        exp_q.push_back(0); exp_q.push_back(1);
        begin
            int k = 0;
            while (!starve[1] && k < 30) begin
                @(negedge sys_clk);
                k++;
            end
            chk("starve_cycles", 32'(k), 32'd8);
        end
        chk("starve_owner_ch0", 32'(grant_idx), 32'd0);
        pulse_done();
        chk("starve_preempt", 32'(grant_valid), 32'd0);
        @(negedge sys_clk);
        chk("starve_grant_ch1", 32'(grant_idx), 32'd1);
        chk("starve_clear", 32'(starve[1]), 32'd0);
        req = 4'b0000;
        pulse_done();
`else
        // Without the feature, starve stays low however long a channel waits.
        req = 4'b0011;
        exp_q.push_back(1);
        wait_grant();
        repeat (12) @(negedge sys_clk);
        chk("starve_off", 32'(starve), 32'd0);
        req = 4'b0000;
        pulse_done();
`endif

        @(negedge sys_clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
